// File: rtl/cc_frame_pkg.sv
// Shared types and constants for the UART command-frame controller.
// Holds the FSM state encoding, frame byte values and rejection codes.
package cc_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_LEN,
    PAYLOAD,
    GET_CKSUM,
    COMMIT
  } state_e;

  localparam logic [7:0] SOF           = 8'hA5;
  localparam logic [7:0] CMD_LOAD_KEY  = 8'h01;
  localparam logic [7:0] CMD_LOAD_DATA = 8'h02;
  localparam logic [7:0] CMD_START     = 8'h03;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_BAD_CMD    = 3'd1;
  localparam logic [2:0] ERR_BAD_LEN    = 3'd2;
  localparam logic [2:0] ERR_BAD_CKSUM  = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT    = 3'd4;
  localparam logic [2:0] ERR_RX_FRAMING = 3'd5;
  localparam logic [2:0] ERR_BUSY       = 3'd6;

  function automatic logic is_known_cmd(input logic [7:0] cmd);
    return (cmd == CMD_LOAD_KEY) || (cmd == CMD_LOAD_DATA) || (cmd == CMD_START);
  endfunction

  // 64-bit intermediate keeps bytes*10*CLK_FREQ from overflowing 32 bits.
  function automatic int timeout_cycles(input int bytes, input int clk_hz, input int baud);
    return int'((longint'(bytes) * 10 * longint'(clk_hz)) / longint'(baud));
  endfunction

endpackage

// File: rtl/cc_frame_ctrl_timer.sv
// Inter-byte timeout counter: cleared on every received byte, held at 0 while disabled.
// expired is raised the cycle before the count reaches T-1 so the registered error lands with it.
module frame_timer #(
  parameter int T = 400
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (T > 2) ? $clog2(T) : 1;
  localparam logic [CW-1:0] LAST = CW'(T - 1);
  localparam logic [CW-1:0] ARM  = CW'(T - 2);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear || !enable) begin
      count_d = '0;
    end else if (count_q != LAST) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && !clear && (count_q == ARM);

endmodule

// File: rtl/cc_frame_ctrl.sv
// Parses UART bytes into command frames and, once the checksum verifies,
// replays the buffered payload as key/data register writes or issues a cipher start.
module cc_frame_ctrl
  import cc_frame_pkg::*;
#(
  parameter int CLK_FREQ      = 30_000_000,
  parameter int BAUD          = 9600,
  parameter int KEY_BYTES     = 16,
  parameter int BLOCK_BYTES   = 16,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       rx_valid,
  input  logic       cipher_busy,
  output logic       wr_en,
  output logic       wr_sel,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cipher_start,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code
);

  localparam int BUF_DEPTH = (KEY_BYTES > BLOCK_BYTES) ? KEY_BYTES : BLOCK_BYTES;
  localparam int IDX_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int T         = timeout_cycles(TIMEOUT_BYTES, CLK_FREQ, BAUD);

  state_e     state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cksum_q, cksum_d;

  logic       wr_en_q, wr_en_d;
  logic       wr_sel_q, wr_sel_d;
  logic [3:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       cipher_start_q, cipher_start_d;
  logic       frame_ok_q, frame_ok_d;
  logic       frame_err_q, frame_err_d;
  logic [2:0] err_code_q, err_code_d;

  logic [7:0]       buf_q [BUF_DEPTH];
  logic             buf_we;
  logic [IDX_W-1:0] buf_idx;

  logic       byte_in;
  logic       in_frame;
  logic       timer_expired;
  logic       err_fire;
  logic [2:0] err_val;
  logic       len_ok;

  assign byte_in  = rx_done && rx_valid;
  assign in_frame = (state_q != IDLE) && (state_q != COMMIT);
  assign buf_idx  = cnt_q[IDX_W-1:0];
  assign len_ok   = ((cmd_q == CMD_LOAD_KEY)  && (rx_data == 8'(KEY_BYTES)))   ||
                    ((cmd_q == CMD_LOAD_DATA) && (rx_data == 8'(BLOCK_BYTES))) ||
                    ((cmd_q == CMD_START)     && (rx_data == 8'd0));

  frame_timer #(
    .T(T)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rx_done),
    .enable (in_frame),
    .expired(timer_expired)
  );

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    len_d          = len_q;
    cnt_d          = cnt_q;
    cksum_d        = cksum_q;
    wr_en_d        = 1'b0;
    wr_sel_d       = 1'b0;
    wr_addr_d      = 4'd0;
    wr_data_d      = 8'd0;
    cipher_start_d = 1'b0;
    frame_ok_d     = 1'b0;
    frame_err_d    = 1'b0;
    err_code_d     = err_code_q;
    buf_we         = 1'b0;
    err_fire       = 1'b0;
    err_val        = ERR_NONE;

    case (state_q)
      IDLE: begin
        if (byte_in && (rx_data == SOF)) begin
          state_d = GET_CMD;
        end
      end

      GET_CMD: begin
        if (byte_in) begin
          if (is_known_cmd(rx_data)) begin
            cmd_d   = rx_data;
            cksum_d = rx_data;
            state_d = GET_LEN;
          end else begin
            err_fire = 1'b1;
            err_val  = ERR_BAD_CMD;
          end
        end
      end

      GET_LEN: begin
        if (byte_in) begin
          if (len_ok) begin
            len_d   = rx_data;
            cksum_d = cksum_q ^ rx_data;
            cnt_d   = 8'd0;
            state_d = (rx_data == 8'd0) ? GET_CKSUM : PAYLOAD;
          end else begin
            err_fire = 1'b1;
            err_val  = ERR_BAD_LEN;
          end
        end
      end

      PAYLOAD: begin
        if (byte_in) begin
          buf_we  = 1'b1;
          cksum_d = cksum_q ^ rx_data;
          cnt_d   = cnt_q + 8'd1;
          if ((cnt_q + 8'd1) == len_q) begin
            state_d = GET_CKSUM;
          end
        end
      end

      GET_CKSUM: begin
        if (byte_in) begin
          if (rx_data != cksum_q) begin
            err_fire = 1'b1;
            err_val  = ERR_BAD_CKSUM;
          end else if (cmd_q == CMD_START) begin
            if (cipher_busy) begin
              err_fire = 1'b1;
              err_val  = ERR_BUSY;
            end else begin
              cipher_start_d = 1'b1;
              frame_ok_d     = 1'b1;
              cksum_d        = 8'd0;
              cnt_d          = 8'd0;
              state_d        = IDLE;
            end
          end else begin
            // Issue write 0 on the same edge that enters COMMIT so write k lands at +1+k.
            wr_en_d   = 1'b1;
            wr_sel_d  = (cmd_q == CMD_LOAD_DATA);
            wr_addr_d = 4'd0;
            wr_data_d = buf_q[0];
            cnt_d     = 8'd1;
            state_d   = COMMIT;
          end
        end
      end

      COMMIT: begin
        if (cnt_q < len_q) begin
          wr_en_d   = 1'b1;
          wr_sel_d  = (cmd_q == CMD_LOAD_DATA);
          wr_addr_d = cnt_q[3:0];
          wr_data_d = buf_q[buf_idx];
          cnt_d     = cnt_q + 8'd1;
        end else begin
          frame_ok_d = 1'b1;
          cksum_d    = 8'd0;
          cnt_d      = 8'd0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (in_frame) begin
      if (rx_done && !rx_valid) begin
        err_fire = 1'b1;
        err_val  = ERR_RX_FRAMING;
      end else if (timer_expired) begin
        err_fire = 1'b1;
        err_val  = ERR_TIMEOUT;
      end
    end

    if (err_fire) begin
      state_d        = IDLE;
      cnt_d          = 8'd0;
      cksum_d        = 8'd0;
      buf_we         = 1'b0;
      wr_en_d        = 1'b0;
      wr_sel_d       = 1'b0;
      wr_addr_d      = 4'd0;
      wr_data_d      = 8'd0;
      cipher_start_d = 1'b0;
      frame_ok_d     = 1'b0;
      frame_err_d    = 1'b1;
      err_code_d     = err_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cmd_q          <= 8'd0;
      len_q          <= 8'd0;
      cnt_q          <= 8'd0;
      cksum_q        <= 8'd0;
      wr_en_q        <= 1'b0;
      wr_sel_q       <= 1'b0;
      wr_addr_q      <= 4'd0;
      wr_data_q      <= 8'd0;
      cipher_start_q <= 1'b0;
      frame_ok_q     <= 1'b0;
      frame_err_q    <= 1'b0;
      err_code_q     <= ERR_NONE;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      len_q          <= len_d;
      cnt_q          <= cnt_d;
      cksum_q        <= cksum_d;
      wr_en_q        <= wr_en_d;
      wr_sel_q       <= wr_sel_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      cipher_start_q <= cipher_start_d;
      frame_ok_q     <= frame_ok_d;
      frame_err_q    <= frame_err_d;
      err_code_q     <= err_code_d;
    end
  end

  // Payload buffer carries no reset; its contents only matter after a full frame arrives.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[buf_idx] <= rx_data;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_sel       = wr_sel_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cipher_start = cipher_start_q;
  assign frame_ok     = frame_ok_q;
  assign frame_err    = frame_err_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_cc_frame_ctrl.sv
// Self-checking bench for cc_frame_ctrl: a byte-level vector table for header/START
// frames plus directed sequences for LOAD commits, checksum errors, timeout and reset.
module tb_cc_frame_ctrl;

  localparam int CLK_FREQ      = 96_000;
  localparam int BAUD          = 9600;
  localparam int KEY_BYTES     = 16;
  localparam int BLOCK_BYTES   = 16;
  localparam int TIMEOUT_BYTES = 4;
  // 4 bytes * 10 bits * 96000 / 9600 = 400 cycles
  localparam int T = 400;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       rx_valid = 1'b0;
  logic       cipher_busy = 1'b0;
  logic       wr_en, wr_sel, cipher_start, frame_ok, frame_err;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] err_code;

  cc_frame_ctrl #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD         (BAUD),
    .KEY_BYTES    (KEY_BYTES),
    .BLOCK_BYTES  (BLOCK_BYTES),
    .TIMEOUT_BYTES(TIMEOUT_BYTES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .rx_valid    (rx_valid),
    .cipher_busy (cipher_busy),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .cipher_start(cipher_start),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Negedge monitor: logs every write and every ok/err pulse with its cycle number.
  logic [7:0]  w_data [256];
  logic [3:0]  w_addr [256];
  logic        w_sel  [256];
  int unsigned w_cyc  [256];
  int          wcount = 0;
  int          ok_count = 0;
  int          err_count = 0;
  int unsigned ok_cyc = 0;
  int unsigned err_cyc = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      w_data[wcount & 255] = wr_data;
      w_addr[wcount & 255] = wr_addr;
      w_sel[wcount & 255]  = wr_sel;
      w_cyc[wcount & 255]  = cyc;
      wcount = wcount + 1;
    end
    if (frame_ok) begin
      ok_count = ok_count + 1;
      ok_cyc   = cyc;
    end
    if (frame_err) begin
      err_count = err_count + 1;
      err_cyc   = cyc;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       exp_start;
    logic       exp_ok;
    logic       exp_err;
    logic [2:0] exp_code;
  } vec_t;

  vec_t        vecs[$];
  int unsigned last_rx_cyc = 0;

  task automatic addVec(input logic [7:0] d, input logic v, input logic b,
                        input logic s, input logic ok, input logic er, input logic [2:0] code);
    vec_t r;
    r.data = d; r.valid = v; r.busy = b;
    r.exp_start = s; r.exp_ok = ok; r.exp_err = er; r.exp_code = code;
    vecs.push_back(r);
  endtask

  // Drives one cycle of inputs starting 1ns after a rising edge; returns 1ns after the next one.
  task automatic applyStimulus(input logic [7:0] d, input logic done, input logic v, input logic b);
    rx_data     = d;
    rx_done     = done;
    rx_valid    = v;
    cipher_busy = b;
    if (done) last_rx_cyc = cyc;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] d);
    applyStimulus(d, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sends A5 cmd 10, payload first..first+15 (last byte inverted if corrupt), then the good checksum.
  task automatic sendLoad(input logic [7:0] cmd, input logic [7:0] first, input logic corrupt);
    logic [7:0] cks;
    logic [7:0] p;
    cks = cmd ^ 8'h10;
    sendByte(8'hA5);
    sendByte(cmd);
    sendByte(8'h10);
    for (int k = 0; k < 16; k++) begin
      p   = first + 8'(k);
      cks = cks ^ p;
      if (corrupt && k == 15) p = ~p;
      sendByte(p);
    end
    sendByte(cks);
  endtask

  task automatic waitOk(input int base, input int budget);
    for (int i = 0; i < budget && ok_count == base; i++) idle(1);
  endtask

  task automatic verifyWrites(input string tag, input int base, input int unsigned cks_cyc,
                              input logic sel, input logic [7:0] first);
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("%s_w%0d", tag, k),
                  {11'd0, w_sel[(base + k) & 255], w_addr[(base + k) & 255],
                   w_data[(base + k) & 255], 8'(w_cyc[(base + k) & 255] - cks_cyc)},
                  {11'd0, sel, 4'(k), first + 8'(k), 8'(1 + k)});
    end
  endtask

  int          base_w, base_ok, base_err;
  int unsigned cks_cyc, stall_cyc;

  initial begin
    $display("[TB] start, timeout period %0d cycles", T);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs",
                {12'd0, wr_en, wr_sel, wr_addr, wr_data, cipher_start, frame_ok, frame_err, err_code},
                32'd0);
    rst_n = 1'b1;
    idle(2);
    checkOutput("post_reset_outputs",
                {12'd0, wr_en, wr_sel, wr_addr, wr_data, cipher_start, frame_ok, frame_err, err_code},
                32'd0);

    // data, valid, busy, exp start/ok/err/code, checked the cycle after each rx_done
    addVec(8'h00, 1, 0, 0, 0, 0, 3'd0);
    addVec(8'hFF, 1, 0, 0, 0, 0, 3'd0);
    addVec(8'hA5, 1, 0, 0, 0, 0, 3'd0);
    addVec(8'h03, 1, 0, 0, 0, 0, 3'd0);
    addVec(8'h00, 1, 0, 0, 0, 0, 3'd0);
    addVec(8'h03, 1, 0, 1, 1, 0, 3'd0);
    addVec(8'hA5, 1, 0, 0, 0, 0, 3'd0);
    addVec(8'h03, 1, 0, 0, 0, 0, 3'd0);
    addVec(8'h00, 1, 0, 0, 0, 0, 3'd0);
    addVec(8'h03, 1, 1, 0, 0, 1, 3'd6);
    addVec(8'hA5, 1, 0, 0, 0, 0, 3'd6);
    addVec(8'h07, 1, 0, 0, 0, 1, 3'd1);
    addVec(8'hA5, 1, 0, 0, 0, 0, 3'd1);
    addVec(8'h01, 1, 0, 0, 0, 0, 3'd1);
    addVec(8'h08, 1, 0, 0, 0, 1, 3'd2);
    addVec(8'hA5, 1, 0, 0, 0, 0, 3'd2);
    addVec(8'h01, 1, 0, 0, 0, 0, 3'd2);
    addVec(8'h10, 1, 0, 0, 0, 0, 3'd2);
    addVec(8'h00, 1, 0, 0, 0, 0, 3'd2);
    addVec(8'h01, 1, 0, 0, 0, 0, 3'd2);
    addVec(8'h55, 0, 0, 0, 0, 1, 3'd5);
    addVec(8'hA5, 0, 0, 0, 0, 0, 3'd5);
    addVec(8'h03, 1, 0, 0, 0, 0, 3'd5);
    addVec(8'hA5, 1, 0, 0, 0, 0, 3'd5);
    addVec(8'h03, 1, 0, 0, 0, 0, 3'd5);
    addVec(8'h00, 1, 0, 0, 0, 0, 3'd5);
    addVec(8'h03, 1, 1, 0, 0, 1, 3'd6);
    addVec(8'hA5, 1, 0, 0, 0, 0, 3'd6);
    addVec(8'h03, 1, 0, 0, 0, 0, 3'd6);
    addVec(8'h00, 1, 0, 0, 0, 0, 3'd6);
    addVec(8'h03, 1, 0, 1, 1, 0, 3'd6);

    base_w = wcount;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].data, 1'b1, vecs[i].valid, vecs[i].busy);
      checkOutput($sformatf("vec%0d", i),
                  {26'd0, cipher_start, frame_ok, frame_err, err_code},
                  {26'd0, vecs[i].exp_start, vecs[i].exp_ok, vecs[i].exp_err, vecs[i].exp_code});
    end
    idle(2);
    checkOutput("vec_no_writes", wcount - base_w, 0);

    // LOAD_KEY 00..0F, checksum 0x11: 16 key writes then frame_ok
    base_w = wcount; base_ok = ok_count; base_err = err_count;
    sendLoad(8'h01, 8'h00, 1'b0);
    cks_cyc = last_rx_cyc;
    waitOk(base_ok, 40);
    checkOutput("key_ok_count", ok_count - base_ok, 1);
    checkOutput("key_ok_cycle", ok_cyc - cks_cyc, 17);
    checkOutput("key_write_count", wcount - base_w, 16);
    checkOutput("key_no_err", err_count - base_err, 0);
    verifyWrites("key", base_w, cks_cyc, 1'b0, 8'h00);

    // LOAD_DATA with last payload byte inverted: bad checksum, nothing written
    idle(3);
    base_w = wcount; base_ok = ok_count; base_err = err_count;
    sendLoad(8'h02, 8'h20, 1'b1);
    checkOutput("cks_err_pulse", {28'd0, frame_ok, frame_err, err_code}, {28'd0, 1'b0, 1'b1, 3'd3});
    idle(20);
    checkOutput("cks_no_writes", wcount - base_w, 0);
    checkOutput("cks_no_ok", ok_count - base_ok, 0);

    // Correct LOAD_DATA 20..2F, checksum 0x12: 16 data writes
    base_w = wcount; base_ok = ok_count;
    sendLoad(8'h02, 8'h20, 1'b0);
    cks_cyc = last_rx_cyc;
    waitOk(base_ok, 40);
    checkOutput("data_ok_cycle", ok_cyc - cks_cyc, 17);
    checkOutput("data_write_count", wcount - base_w, 16);
    checkOutput("data_err_code_held", {29'd0, err_code}, 3);
    verifyWrites("data", base_w, cks_cyc, 1'b1, 8'h20);

    // Stall after 5 payload bytes: timeout error exactly T cycles after last rx_done
    idle(3);
    base_w = wcount; base_err = err_count;
    sendByte(8'hA5); sendByte(8'h01); sendByte(8'h10);
    for (int k = 0; k < 5; k++) sendByte(8'(k));
    stall_cyc = last_rx_cyc;
    for (int i = 0; i < T + 20 && err_count == base_err; i++) idle(1);
    checkOutput("timeout_err_count", err_count - base_err, 1);
    checkOutput("timeout_delay", err_cyc - stall_cyc, T);
    checkOutput("timeout_code", {29'd0, err_code}, 4);
    checkOutput("timeout_no_writes", wcount - base_w, 0);

    // Reset asserted while write 7 is on the bus
    idle(2);
    base_w = wcount; base_ok = ok_count;
    sendLoad(8'h01, 8'h00, 1'b0);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    checkOutput("commit_at_write7", {27'd0, wr_en, wr_addr}, {27'd0, 1'b1, 4'd7});
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_commit",
                {12'd0, wr_en, wr_sel, wr_addr, wr_data, cipher_start, frame_ok, frame_err, err_code},
                32'd0);
    idle(4);
    checkOutput("reset_writes_stopped", wcount - base_w, 7);
    checkOutput("reset_no_ok", ok_count - base_ok, 0);
    rst_n = 1'b1;
    idle(2);
    sendByte(8'hA5); sendByte(8'h03); sendByte(8'h00);
    applyStimulus(8'h03, 1'b1, 1'b1, 1'b0);
    checkOutput("start_after_reset", {28'd0, cipher_start, frame_ok, frame_err, 1'b0},
                {28'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
